ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Execute stage of the 5-stage RV32I pipeline, directly upstream of the memory/write-back stage. It takes the decoded instruction from the ID/EX latches and computes the ALU result, effective address, or link value. It resolves branches and jumps, and registers everything into the EX/MEM latches consumed by the memory stage. It also issues a one-cycle redirect pulse to fetch and squashes the single wrong-path instruction already in ID/EX.

## Interface
- Parameters: NOP_IR, 32'h00000013, bubble encoding (addi x0,x0,0)
- clk1  in  1  pipeline clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all EX/MEM registers and state this cycle
- ID_EX_valid  in  1  ID/EX holds a real instruction
- ID_EX_IR  in  32  instruction word
- ID_EX_PC  in  32  instruction address
- ID_EX_A  in  32  rs1 value
- ID_EX_B  in  32  rs2 value
- ID_EX_Imm  in  32  sign-extended immediate (U-type already shifted)
- ID_EX_type  in  3  R=011, S=010, B=111, U=101, I_jump(jalr)=110, I_logic=001, I_load=000, J(jal)=100
- EX_MEM_ALUOUT  out  32  result / effective address / link value
- EX_MEM_IR  out  32  instruction word
- EX_MEM_type  out  3  type code passed on
- EX_MEM_B  out  32  store data; drives the memory stage's rs2 input
- EX_MEM_valid  out  1  EX/MEM holds a real instruction
- branch_taken  out  1  redirect pulse to fetch; upstream clears IF/ID
- branch_target  out  32  redirect address, valid while branch_taken=1

## Operation
- Arithmetic is 32-bit with wrap-around; the shift amount is operand[4:0].
- R: funct3 plus IR[30] select add/sub, sll, slt, sltu, xor, srl/sra, or, and.
- I_logic: same operations with Imm as the second operand. There is no sub. IR[30] selects srai vs srli.
- I_load and S: ALUOUT = A + Imm.
- U: ALUOUT = Imm when IR[5]=1 (lui), else PC + Imm (auipc).
- J: ALUOUT = PC + 4; target = PC + Imm; always taken.
- I_jump: ALUOUT = PC + 4; target = (A + Imm) & ~1; always taken.
- B: funct3 selects the condition: beq, bne, blt, bge (signed), bltu, bgeu (unsigned). Target = PC + Imm, and ALUOUT = target. Taken only if the condition holds.
- Any other type code produces a bubble.
- Bubble contents: IR = NOP_IR, type = I_logic, ALUOUT = 0, B = 0, valid = 0.
- The state machine has two states, RUN and SQUASH.
  - In RUN, a valid ID/EX instruction is executed. If it is taken, the block registers branch_taken=1 and branch_target, then moves to SQUASH.
  - In SQUASH, the ID/EX contents are converted to a bubble regardless of ID_EX_valid and type. No redirect is generated, even for a taken branch or jump. The state returns to RUN.
- An ID_EX_valid=0 input always produces a bubble and leaves the state unchanged (RUN stays RUN; SQUASH consumes it and returns to RUN).

## Timing
- Latency is 1 cycle: ID/EX at edge N appears on the EX/MEM outputs after edge N.
- branch_taken is high for exactly one cycle, the cycle the branch/jump occupies EX/MEM.
- branch_target holds its value until the next redirect.
- stall=1:
  - EX/MEM outputs, EX_MEM_valid, branch_target, and the state hold.
  - branch_taken is forced to 0 after its first cycle, so a redirect is never repeated.
  - A SQUASH pending across the stall persists until the first non-stalled edge.
- Reset values: EX_MEM_IR = NOP_IR, EX_MEM_type = I_logic (001), EX_MEM_ALUOUT = 0, EX_MEM_B = 0, EX_MEM_valid = 0, branch_taken = 0, branch_target = 0, state = RUN.
- rst has priority over stall.
- Reset mid-SQUASH returns to RUN; the next instruction after reset is not squashed.
- Back-to-back taken branches: the second branch is in the squash slot and is discarded.

## Test plan
- Reset: assert rst with stall=1 and a valid add in ID/EX -> after the edge, IR=32'h00000013, type=001, ALUOUT=0, valid=0, branch_taken=0.
- ALU: R sub with A=5, B=7 -> ALUOUT=32'hFFFFFFFE. srai with A=32'h80000000, Imm[4:0]=4 -> 32'hF8000000. sltu with A=1, B=32'hFFFFFFFF -> 1. lui with Imm=32'h12345000 -> 32'h12345000.
- Taken branch: blt with PC=32'h100, A=-1, B=1, Imm=32'h20, followed by add x1 -> branch_taken=1 for one cycle with target 32'h120. The add leaves as a bubble (valid=0, IR=NOP).
- Not-taken/signedness: bltu with A=-1, B=1 -> branch_taken=0, and the next instruction executes normally.
- jalr: PC=32'h40, A=32'h203, Imm=0 -> ALUOUT=32'h44, target=32'h202. A jal occupying the squash slot produces no second pulse.
- Stall: assert stall for 3 cycles right after a taken beq -> branch_taken high only 1 cycle, outputs frozen. The first instruction after the stall is squashed. rst during SQUASH -> the next instruction executes.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage of the 5-stage RV32I pipeline.
// Computes the ALU result, effective address or link value for the instruction held in the
// ID/EX latches, resolves branches and jumps, and registers the outcome into the EX/MEM latches.
// A taken branch or jump raises a one-cycle redirect to fetch and squashes the single
// wrong-path instruction that follows it into ID/EX.
//
// Ports:
//   clk1, rst            pipeline clock, synchronous active-high reset
//   stall                hold EX/MEM registers and state this cycle
//   ID_EX_*              decoded instruction: valid, IR, PC, A (rs1), B (rs2), Imm, type code
//   EX_MEM_*             registered result, IR, type code, store data, valid
//   branch_taken         one-cycle redirect pulse to fetch
//   branch_target        redirect address, held until the next redirect
module ex_mem_stage #(
    parameter logic [31:0] NOP_IR = 32'h00000013
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        stall,
    input  logic        ID_EX_valid,
    input  logic [31:0] ID_EX_IR,
    input  logic [31:0] ID_EX_PC,
    input  logic [31:0] ID_EX_A,
    input  logic [31:0] ID_EX_B,
    input  logic [31:0] ID_EX_Imm,
    input  logic [2:0]  ID_EX_type,
    output logic [31:0] EX_MEM_ALUOUT,
    output logic [31:0] EX_MEM_IR,
    output logic [2:0]  EX_MEM_type,
    output logic [31:0] EX_MEM_B,
    output logic        EX_MEM_valid,
    output logic        branch_taken,
    output logic [31:0] branch_target
);

    localparam logic [2:0] TypeLoad  = 3'b000;
    localparam logic [2:0] TypeLogic = 3'b001;
    localparam logic [2:0] TypeStore = 3'b010;
    localparam logic [2:0] TypeR     = 3'b011;
    localparam logic [2:0] TypeJal   = 3'b100;
    localparam logic [2:0] TypeU     = 3'b101;
    localparam logic [2:0] TypeJalr  = 3'b110;
    localparam logic [2:0] TypeB     = 3'b111;

    typedef enum logic [0:0] {StRun, StSquash} state_e;

    state_e state_q, state_d;

    logic [2:0]  funct3;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic        br_cond;
    logic        ex_ok;
    logic [31:0] ex_out;
    logic        ex_taken;
    logic [31:0] ex_target;

    logic [31:0] aluout_d, ir_d, b_d, target_d;
    logic [2:0]  type_d;
    logic        valid_d, taken_d;

    assign funct3 = ID_EX_IR[14:12];
    assign op_b   = (ID_EX_type == TypeR) ? ID_EX_B : ID_EX_Imm;
    assign shamt  = op_b[4:0];

    // Shared integer ALU for R and I_logic; sub exists only for R.
    always_comb begin
        alu_res = 32'd0;
        case (funct3)
            3'b000: alu_res = (ID_EX_type == TypeR && ID_EX_IR[30]) ? ID_EX_A - op_b
                                                                     : ID_EX_A + op_b;
            3'b001: alu_res = ID_EX_A << shamt;
            3'b010: alu_res = {31'd0, $signed(ID_EX_A) < $signed(op_b)};
            3'b011: alu_res = {31'd0, ID_EX_A < op_b};
            3'b100: alu_res = ID_EX_A ^ op_b;
            3'b101: alu_res = ID_EX_IR[30] ? 32'($signed(ID_EX_A) >>> shamt)
                                           : ID_EX_A >> shamt;
            3'b110: alu_res = ID_EX_A | op_b;
            default: alu_res = ID_EX_A & op_b;
        endcase
    end

    // Branch condition; funct3 010/011 are not branch encodings and never take.
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000: br_cond = (ID_EX_A == ID_EX_B);
            3'b001: br_cond = (ID_EX_A != ID_EX_B);
            3'b100: br_cond = ($signed(ID_EX_A) < $signed(ID_EX_B));
            3'b101: br_cond = ($signed(ID_EX_A) >= $signed(ID_EX_B));
            3'b110: br_cond = (ID_EX_A < ID_EX_B);
            3'b111: br_cond = (ID_EX_A >= ID_EX_B);
            default: br_cond = 1'b0;
        endcase
    end

    // Per-type result, redirect decision and target.
    always_comb begin
        ex_ok     = 1'b1;
        ex_out    = 32'd0;
        ex_taken  = 1'b0;
        ex_target = ID_EX_PC + ID_EX_Imm;
        case (ID_EX_type)
            TypeR, TypeLogic:   ex_out = alu_res;
            TypeLoad, TypeStore: ex_out = ID_EX_A + ID_EX_Imm;
            TypeU:              ex_out = ID_EX_IR[5] ? ID_EX_Imm : ID_EX_PC + ID_EX_Imm;
            TypeJal: begin
                ex_out   = ID_EX_PC + 32'd4;
                ex_taken = 1'b1;
            end
            TypeJalr: begin
                ex_out    = ID_EX_PC + 32'd4;
                ex_target = (ID_EX_A + ID_EX_Imm) & ~32'd1;
                ex_taken  = 1'b1;
            end
            TypeB: begin
                ex_out   = ID_EX_PC + ID_EX_Imm;
                ex_taken = br_cond;
            end
            default: ex_ok = 1'b0;
        endcase
    end

    // Next-state: stall holds everything except the redirect pulse, which drops after one cycle.
    always_comb begin
        state_d  = state_q;
        aluout_d = EX_MEM_ALUOUT;
        ir_d     = EX_MEM_IR;
        type_d   = EX_MEM_type;
        b_d      = EX_MEM_B;
        valid_d  = EX_MEM_valid;
        taken_d  = 1'b0;
        target_d = branch_target;
        if (!stall) begin
            // Bubble by default; overwritten only when a real instruction executes.
            aluout_d = 32'd0;
            ir_d     = NOP_IR;
            type_d   = TypeLogic;
            b_d      = 32'd0;
            valid_d  = 1'b0;
            state_d  = StRun;
            if (state_q == StRun && ID_EX_valid && ex_ok) begin
                aluout_d = ex_out;
                ir_d     = ID_EX_IR;
                type_d   = ID_EX_type;
                b_d      = ID_EX_B;
                valid_d  = 1'b1;
                if (ex_taken) begin
                    taken_d  = 1'b1;
                    target_d = ex_target;
                    state_d  = StSquash;
                end
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q       <= StRun;
            EX_MEM_ALUOUT <= 32'd0;
            EX_MEM_IR     <= NOP_IR;
            EX_MEM_type   <= TypeLogic;
            EX_MEM_B      <= 32'd0;
            EX_MEM_valid  <= 1'b0;
            branch_taken  <= 1'b0;
            branch_target <= 32'd0;
        end else begin
            state_q       <= state_d;
            EX_MEM_ALUOUT <= aluout_d;
            EX_MEM_IR     <= ir_d;
            EX_MEM_type   <= type_d;
            EX_MEM_B      <= b_d;
            EX_MEM_valid  <= valid_d;
            branch_taken  <= taken_d;
            branch_target <= target_d;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage.
module tb_ex_mem_stage;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [2:0] T_LD = 3'b000, T_IL = 3'b001, T_S = 3'b010, T_R = 3'b011;
    localparam logic [2:0] T_J = 3'b100, T_U = 3'b101, T_JR = 3'b110, T_B = 3'b111;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_B = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

    logic        clk1 = 1'b0;
    logic        rst, stall, ID_EX_valid;
    logic [31:0] ID_EX_IR, ID_EX_PC, ID_EX_A, ID_EX_B, ID_EX_Imm;
    logic [2:0]  ID_EX_type;
    logic [31:0] EX_MEM_ALUOUT, EX_MEM_IR, EX_MEM_B, branch_target;
    logic [2:0]  EX_MEM_type;
    logic        EX_MEM_valid, branch_taken;

    int n_tests = 0;
    int n_fail  = 0;

    ex_mem_stage #(.NOP_IR(NOP)) dut (
        .clk1(clk1), .rst(rst), .stall(stall),
        .ID_EX_valid(ID_EX_valid), .ID_EX_IR(ID_EX_IR), .ID_EX_PC(ID_EX_PC),
        .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B), .ID_EX_Imm(ID_EX_Imm), .ID_EX_type(ID_EX_type),
        .EX_MEM_ALUOUT(EX_MEM_ALUOUT), .EX_MEM_IR(EX_MEM_IR), .EX_MEM_type(EX_MEM_type),
        .EX_MEM_B(EX_MEM_B), .EX_MEM_valid(EX_MEM_valid),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic b30, input logic [2:0] f3,
                                       input logic [6:0] op);
        return {1'b0, b30, 5'd0, 5'd3, 5'd2, f3, 5'd1, op};
    endfunction

    task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] ir,
                         input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm);
        ID_EX_valid = v;
        ID_EX_type  = t;
        ID_EX_IR    = ir;
        ID_EX_PC    = pc;
        ID_EX_A     = a;
        ID_EX_B     = b;
        ID_EX_Imm   = imm;
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".valid"}, {31'd0, EX_MEM_valid}, 32'd0);
        check({tag, ".ir"}, EX_MEM_IR, NOP);
        check({tag, ".type"}, {29'd0, EX_MEM_type}, {29'd0, T_IL});
        check({tag, ".alu"}, EX_MEM_ALUOUT, 32'd0);
        check({tag, ".bt"}, {31'd0, branch_taken}, 32'd0);
    endtask

    logic [31:0] add_ir, beq_ir;

    initial begin
        add_ir = mk(1'b0, 3'b000, OP_R);
        beq_ir = mk(1'b0, 3'b000, OP_B);

        // Reset has priority over stall.
        rst = 1'b1;
        stall = 1'b1;
        drive(1'b1, T_R, add_ir, 32'h0, 32'd1, 32'd2, 32'd0);
        step();
        check_bubble("reset");
        check("reset.b", EX_MEM_B, 32'd0);
        check("reset.tgt", branch_target, 32'd0);

        rst = 1'b0;
        stall = 1'b0;
        drive(1'b1, T_R, mk(1'b1, 3'b000, OP_R), 32'h10, 32'd5, 32'd7, 32'd0);
        step();
        check("sub.alu", EX_MEM_ALUOUT, 32'hFFFFFFFE);
        check("sub.valid", {31'd0, EX_MEM_valid}, 32'd1);
        check("sub.ir", EX_MEM_IR, mk(1'b1, 3'b000, OP_R));
        check("sub.type", {29'd0, EX_MEM_type}, {29'd0, T_R});
        check("sub.b", EX_MEM_B, 32'd7);

        drive(1'b1, T_IL, mk(1'b1, 3'b101, OP_I), 32'h14, 32'h80000000, 32'd0, 32'd4);
        step();
        check("srai.alu", EX_MEM_ALUOUT, 32'hF8000000);

        drive(1'b1, T_R, mk(1'b0, 3'b011, OP_R), 32'h18, 32'd1, 32'hFFFFFFFF, 32'd0);
        step();
        check("sltu.alu", EX_MEM_ALUOUT, 32'd1);

        drive(1'b1, T_U, mk(1'b0, 3'b000, OP_LUI), 32'h1C, 32'd0, 32'd0, 32'h12345000);
        step();
        check("lui.alu", EX_MEM_ALUOUT, 32'h12345000);

        drive(1'b1, T_U, mk(1'b0, 3'b000, OP_AUIPC), 32'h1000, 32'd0, 32'd0, 32'h2000);
        step();
        check("auipc.alu", EX_MEM_ALUOUT, 32'h3000);

        drive(1'b1, T_LD, mk(1'b0, 3'b010, 7'b0000011), 32'h24, 32'h100, 32'd0, 32'hFFFFFFFC);
        step();
        check("lw.alu", EX_MEM_ALUOUT, 32'h0FC);

        // Taken blt, then the wrong-path add is squashed, then execution resumes.
        drive(1'b1, T_B, mk(1'b0, 3'b100, OP_B), 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20);
        step();
        check("blt.bt", {31'd0, branch_taken}, 32'd1);
        check("blt.tgt", branch_target, 32'h120);
        check("blt.alu", EX_MEM_ALUOUT, 32'h120);
        check("blt.valid", {31'd0, EX_MEM_valid}, 32'd1);
        drive(1'b1, T_R, add_ir, 32'h104, 32'd2, 32'd3, 32'd0);
        step();
        check_bubble("blt.squash");
        check("blt.tgt_hold", branch_target, 32'h120);
        drive(1'b1, T_R, add_ir, 32'h120, 32'd2, 32'd3, 32'd0);
        step();
        check("resume.alu", EX_MEM_ALUOUT, 32'd5);
        check("resume.valid", {31'd0, EX_MEM_valid}, 32'd1);

        // Unsigned compare: -1 is large, so bltu is not taken.
        drive(1'b1, T_B, mk(1'b0, 3'b110, OP_B), 32'h200, 32'hFFFFFFFF, 32'd1, 32'h10);
        step();
        check("bltu.bt", {31'd0, branch_taken}, 32'd0);
        check("bltu.alu", EX_MEM_ALUOUT, 32'h210);
        check("bltu.tgt_hold", branch_target, 32'h120);
        drive(1'b1, T_R, add_ir, 32'h204, 32'd10, 32'd20, 32'd0);
        step();
        check("bltu.next.alu", EX_MEM_ALUOUT, 32'd30);
        check("bltu.next.valid", {31'd0, EX_MEM_valid}, 32'd1);

        // jalr clears bit 0; jal in the squash slot is discarded.
        drive(1'b1, T_JR, mk(1'b0, 3'b000, OP_JALR), 32'h40, 32'h203, 32'd0, 32'd0);
        step();
        check("jalr.alu", EX_MEM_ALUOUT, 32'h44);
        check("jalr.tgt", branch_target, 32'h202);
        check("jalr.bt", {31'd0, branch_taken}, 32'd1);
        drive(1'b1, T_J, mk(1'b0, 3'b000, OP_JAL), 32'h44, 32'd0, 32'd0, 32'h100);
        step();
        check_bubble("jal.squash");
        check("jal.tgt_hold", branch_target, 32'h202);

        // Invalid input in RUN is a bubble and does not squash the next one.
        drive(1'b0, T_R, add_ir, 32'h48, 32'd1, 32'd1, 32'd0);
        step();
        check_bubble("invalid");
        drive(1'b1, T_R, mk(1'b0, 3'b111, OP_R), 32'h4C, 32'hF0, 32'h3C, 32'd0);
        step();
        check("and.alu", EX_MEM_ALUOUT, 32'h30);
        check("and.valid", {31'd0, EX_MEM_valid}, 32'd1);

        // Taken beq followed by a 3-cycle stall; squash persists across it.
        drive(1'b1, T_B, beq_ir, 32'h300, 32'd7, 32'd7, 32'd8);
        step();
        check("beq.bt", {31'd0, branch_taken}, 32'd1);
        check("beq.tgt", branch_target, 32'h308);
        stall = 1'b1;
        drive(1'b1, T_R, add_ir, 32'h304, 32'd1, 32'd1, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.bt", {31'd0, branch_taken}, 32'd0);
            check("stall.alu", EX_MEM_ALUOUT, 32'h308);
            check("stall.ir", EX_MEM_IR, beq_ir);
            check("stall.valid", {31'd0, EX_MEM_valid}, 32'd1);
            check("stall.tgt", branch_target, 32'h308);
        end
        stall = 1'b0;
        step();
        check_bubble("stall.squash");
        drive(1'b1, T_R, add_ir, 32'h308, 32'd1, 32'd1, 32'd0);
        step();
        check("poststall.alu", EX_MEM_ALUOUT, 32'd2);
        check("poststall.valid", {31'd0, EX_MEM_valid}, 32'd1);

        // Reset while SQUASH is pending returns to RUN.
        drive(1'b1, T_B, beq_ir, 32'h400, 32'd9, 32'd9, 32'hFFFFFFFC);
        step();
        check("beq2.tgt", branch_target, 32'h3FC);
        rst = 1'b1;
        drive(1'b1, T_R, add_ir, 32'h404, 32'd3, 32'd4, 32'd0);
        step();
        check_bubble("rst_sq");
        check("rst_sq.tgt", branch_target, 32'd0);
        rst = 1'b0;
        step();
        check("rst_sq.next.alu", EX_MEM_ALUOUT, 32'd7);
        check("rst_sq.next.valid", {31'd0, EX_MEM_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
